// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, latency classes and the
// field/immediate helpers used by the decode/issue stage.
package decode_pkg;

   localparam logic [2:0] OP_ALU0 = 3'b000;
   localparam logic [2:0] OP_ALU1 = 3'b001;
   localparam logic [2:0] OP_FPU  = 3'b010;
   localparam logic [2:0] OP_ALU3 = 3'b011;
   localparam logic [2:0] OP_ALUI = 3'b100;
   localparam logic [2:0] OP_MEM  = 3'b101;
   localparam logic [2:0] OP_BR   = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   localparam logic [2:0] FN_ADDR = 3'b010;

   typedef enum logic [1:0] {
      LC_NONE = 2'd0,
      LC_ALU  = 2'd1,
      LC_LOAD = 2'd2,
      LC_FPU  = 2'd3
   } lat_class_e;

   function automatic logic [2:0] get_op(input logic [31:0] i);
      return i[2:0];
   endfunction

   function automatic logic [2:0] get_funct(input logic [31:0] i);
      return i[5:3];
   endfunction

   function automatic logic from_freg(input logic [2:0] op, input logic [2:0] funct);
      return (op == OP_FPU) || ({funct[2], op} == 4'b0011);
   endfunction

   function automatic logic to_freg(input logic [2:0] op, input logic [2:0] funct);
      return (op == OP_FPU) || ({funct[2], op} == 4'b1011);
   endfunction

   // Immediates are sign-extended to 64 bits; callers truncate to XLEN.
   function automatic logic [63:0] imm_il(input logic [31:0] i);
      return {{48{i[21]}}, i[21:6]};
   endfunction

   function automatic logic [63:0] imm_sb(input logic [31:0] i);
      return {{48{i[26]}}, i[26:11]};
   endfunction

   function automatic lat_class_e lat_class_of(input logic [2:0] op, input logic [2:0] funct);
      lat_class_e c;
      case (op)
         OP_FPU:                             c = LC_FPU;
         OP_ALU0, OP_ALU1, OP_ALU3, OP_ALUI: c = LC_ALU;
         OP_MEM: begin
            if (funct[2:1] == 2'b00) begin
               c = LC_LOAD;
            end else if (funct == FN_ADDR) begin
               c = LC_ALU;
            end else begin
               c = LC_NONE;
            end
         end
         default:                            c = LC_NONE;
      endcase
      return c;
   endfunction

   function automatic int unsigned lat_of(input lat_class_e c, input int unsigned load_lat,
                                          input int unsigned fpu_lat);
      int unsigned l;
      case (c)
         LC_LOAD: l = load_lat;
         LC_FPU:  l = fpu_lat;
         default: l = 32'd0;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/decode_scoreboard_reg_scoreboard.sv
// Per-register latency scoreboard: a countdown per register that marks it busy
// until its in-flight multi-cycle result reaches writeback.
module reg_scoreboard #(
   parameter int REG_AW = 6,
   parameter int CW     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adv,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_idx,
   input  logic [CW-1:0]     set_val,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_idx,
   input  logic [REG_AW-1:0] rs1_idx,
   input  logic [REG_AW-1:0] rs2_idx,
   input  logic [REG_AW-1:0] rd_idx,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              rd_busy
);

   localparam int NREG = 1 << REG_AW;

   logic [NREG-1:0][CW-1:0] pend_q, pend_d;
   logic                    set_ok;

   // Next pending counts: a new issue wins over a squash clear, which wins over countdown.
   always_comb begin
      pend_d = pend_q;
      set_ok = set_en && (set_idx[4:0] != 5'd0);
      for (int r = 0; r < NREG; r++) begin
         if (!adv) begin
            pend_d[r] = pend_q[r];
         end else if (set_ok && (set_idx == REG_AW'(r))) begin
            pend_d[r] = set_val;
         end else if (clr_en && (clr_idx == REG_AW'(r))) begin
            pend_d[r] = '0;
         end else if (pend_q[r] != '0) begin
            pend_d[r] = pend_q[r] - CW'(1);
         end else begin
            pend_d[r] = pend_q[r];
         end
      end
   end

   // Pending counter storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign rs1_busy = (pend_q[rs1_idx] != '0);
   assign rs2_busy = (pend_q[rs2_idx] != '0);
   assign rd_busy  = (pend_q[rd_idx]  != '0);

endmodule

// File: rtl/decode_scoreboard.sv
// Decode/issue stage: field decode, operand forwarding, scoreboard-based
// RAW/WAW interlock and the registered decode output bundle.
module decode_scoreboard
   import decode_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int PCW      = 27,
   parameter int REG_AW   = 6,
   parameter int LOAD_LAT = 2,
   parameter int FPU_LAT  = 3,
   parameter int MAX_LAT  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              n_stall,
   input  logic              flush,
   input  logic              inst_valid,
   input  logic [31:0]       inst,
   input  logic [PCW-1:0]    pc,
   output logic              dec_nstall,
   output logic [REG_AW-1:0] rf_rs1,
   output logic [REG_AW-1:0] rf_rs2,
   input  logic [XLEN-1:0]   rf_rs1data,
   input  logic [XLEN-1:0]   rf_rs2data,
   input  logic [XLEN-1:0]   alu_fwd,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              dec_valid,
   output logic [XLEN-1:0]   dec_op1,
   output logic [XLEN-1:0]   dec_op2,
   output logic [6:0]        aluctl,
   output logic [REG_AW:0]   dec_rd,
   output logic              dec_mre,
   output logic              dec_mwe,
   output logic [6:0]        dec_branch,
   output logic [PCW-1:0]    npc,
   output logic [XLEN-3:0]   daddr
);

   localparam int CW = $clog2(MAX_LAT + 1);

   logic [2:0]        op, funct;
   logic              from_f, to_f, writes, is_store, issue;
   logic [REG_AW-1:0] rs1_idx, rs2_idx, rd_idx;
   lat_class_e        cls;
   logic [CW-1:0]     lat;
   logic [XLEN-1:0]   imm_il_v, imm_sb_v, op1, src2, op2, addr_imm;
   logic [6:0]        branch;
   logic              rs1_busy, rs2_busy, rd_busy, clr_en;

   logic              dec_valid_d, dec_valid_q, dec_mre_d, dec_mre_q, dec_mwe_d, dec_mwe_q;
   lat_class_e        cls_d, cls_q;
   logic [XLEN-1:0]   dec_op1_d, dec_op1_q, dec_op2_d, dec_op2_q;
   logic [6:0]        aluctl_d, aluctl_q, dec_branch_d, dec_branch_q;
   logic [REG_AW:0]   dec_rd_d, dec_rd_q;
   logic [PCW-1:0]    npc_d, npc_q;
   logic [XLEN-3:0]   daddr_d, daddr_q;

   // Instruction field decode.
   always_comb begin
      op       = get_op(inst);
      funct    = get_funct(inst);
      from_f   = from_freg(op, funct);
      to_f     = to_freg(op, funct);
      rs1_idx  = REG_AW'({from_f, inst[31:27]});
      rs2_idx  = REG_AW'({from_f, inst[10:6]});
      rd_idx   = REG_AW'({to_f, inst[26:22]});
      cls      = lat_class_of(op, funct);
      writes   = (cls != LC_NONE);
      lat      = CW'(lat_of(cls, LOAD_LAT, FPU_LAT));
      imm_il_v = XLEN'(imm_il(inst));
      imm_sb_v = XLEN'(imm_sb(inst));
      is_store = (op == OP_MEM) && funct[2];
      branch   = 7'd0;
      if (op == OP_BR) begin
         branch[6] = 1'b1;
         if (funct < 3'd6) begin
            branch[funct] = 1'b1;
         end else begin
            branch[5:0] = 6'd0;
         end
      end else begin
         branch = 7'd0;
      end
   end

   // Operand select: the ALU result of the instruction ahead wins over writeback.
   always_comb begin
      if (dec_valid_q && (cls_q == LC_ALU) && (dec_rd_q[REG_AW-1:0] == rs1_idx) &&
          (rs1_idx[4:0] != 5'd0)) begin
         op1 = alu_fwd;
      end else if (wb_we && (wb_rd == rs1_idx) && (rs1_idx[4:0] != 5'd0)) begin
         op1 = wb_data;
      end else begin
         op1 = rf_rs1data;
      end
      if (dec_valid_q && (cls_q == LC_ALU) && (dec_rd_q[REG_AW-1:0] == rs2_idx) &&
          (rs2_idx[4:0] != 5'd0)) begin
         src2 = alu_fwd;
      end else if (wb_we && (wb_rd == rs2_idx) && (rs2_idx[4:0] != 5'd0)) begin
         src2 = wb_data;
      end else begin
         src2 = rf_rs2data;
      end
      if ((op == OP_ALUI) || (op == OP_MEM) || (op == OP_JMP)) begin
         op2 = imm_il_v;
      end else begin
         op2 = src2;
      end
      if (op == OP_MEM) begin
         addr_imm = imm_il_v;
      end else begin
         addr_imm = imm_sb_v;
      end
   end

   assign dec_nstall = ~(inst_valid & (rs1_busy | rs2_busy | (writes & rd_busy)));
   assign issue      = n_stall & inst_valid & dec_nstall & ~flush;
   assign clr_en     = flush & dec_valid_q & ((cls_q == LC_LOAD) | (cls_q == LC_FPU));

   reg_scoreboard #(
      .REG_AW (REG_AW),
      .CW     (CW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .adv      (n_stall),
      .set_en   (issue & (lat != '0)),
      .set_idx  (rd_idx),
      .set_val  (lat),
      .clr_en   (clr_en),
      .clr_idx  (dec_rd_q[REG_AW-1:0]),
      .rs1_idx  (rs1_idx),
      .rs2_idx  (rs2_idx),
      .rd_idx   (rd_idx),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .rd_busy  (rd_busy)
   );

   // Output register next state: hold, squash, issue or bubble.
   always_comb begin
      dec_valid_d  = dec_valid_q;
      cls_d        = cls_q;
      dec_op1_d    = dec_op1_q;
      dec_op2_d    = dec_op2_q;
      aluctl_d     = aluctl_q;
      dec_rd_d     = dec_rd_q;
      dec_mre_d    = dec_mre_q;
      dec_mwe_d    = dec_mwe_q;
      dec_branch_d = dec_branch_q;
      npc_d        = npc_q;
      daddr_d      = daddr_q;
      if (!n_stall) begin
         dec_valid_d = dec_valid_q;
      end else if (flush) begin
         dec_valid_d  = 1'b0;
         cls_d        = LC_NONE;
         dec_op1_d    = '0;
         dec_op2_d    = '0;
         aluctl_d     = 7'd0;
         dec_rd_d     = '0;
         dec_mre_d    = 1'b0;
         dec_mwe_d    = 1'b0;
         dec_branch_d = 7'd0;
         npc_d        = '0;
         daddr_d      = '0;
      end else if (issue) begin
         dec_valid_d  = 1'b1;
         cls_d        = cls;
         dec_op1_d    = op1;
         dec_op2_d    = op2;
         aluctl_d     = {inst[11], op, funct};
         dec_rd_d     = {writes, rd_idx};
         dec_mre_d    = (cls == LC_LOAD);
         dec_mwe_d    = is_store;
         dec_branch_d = branch;
         npc_d        = pc + {imm_sb_v[PCW-3:0], 2'b00};
         daddr_d      = op1[XLEN-3:0] + addr_imm[XLEN-3:0];
      end else begin
         dec_valid_d  = 1'b0;
         cls_d        = LC_NONE;
         aluctl_d     = 7'd0;
         dec_rd_d     = '0;
         dec_mre_d    = 1'b0;
         dec_mwe_d    = 1'b0;
         dec_branch_d = 7'd0;
      end
   end

   // Output register storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_valid_q  <= 1'b0;
         cls_q        <= LC_NONE;
         dec_op1_q    <= '0;
         dec_op2_q    <= '0;
         aluctl_q     <= 7'd0;
         dec_rd_q     <= '0;
         dec_mre_q    <= 1'b0;
         dec_mwe_q    <= 1'b0;
         dec_branch_q <= 7'd0;
         npc_q        <= '0;
         daddr_q      <= '0;
      end else begin
         dec_valid_q  <= dec_valid_d;
         cls_q        <= cls_d;
         dec_op1_q    <= dec_op1_d;
         dec_op2_q    <= dec_op2_d;
         aluctl_q     <= aluctl_d;
         dec_rd_q     <= dec_rd_d;
         dec_mre_q    <= dec_mre_d;
         dec_mwe_q    <= dec_mwe_d;
         dec_branch_q <= dec_branch_d;
         npc_q        <= npc_d;
         daddr_q      <= daddr_d;
      end
   end

   assign rf_rs1     = rs1_idx;
   assign rf_rs2     = rs2_idx;
   assign dec_valid  = dec_valid_q;
   assign dec_op1    = dec_op1_q;
   assign dec_op2    = dec_op2_q;
   assign aluctl     = aluctl_q;
   assign dec_rd     = dec_rd_q;
   assign dec_mre    = dec_mre_q;
   assign dec_mwe    = dec_mwe_q;
   assign dec_branch = dec_branch_q;
   assign npc        = npc_q;
   assign daddr      = daddr_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Randomised bench for decode_scoreboard against a cycle-level reference model
// built from the instruction rules with integer countdowns per register.
module tb_decode_scoreboard;

   localparam int LOAD_LAT = 2;
   localparam int FPU_LAT  = 3;

   logic        clk = 1'b0;
   logic        rst, n_stall, flush, inst_valid, wb_we;
   logic [31:0] inst, rf_rs1data, rf_rs2data, alu_fwd, wb_data;
   logic [26:0] pc;
   logic [5:0]  wb_rd, rf_rs1, rf_rs2;
   logic        dec_nstall, dec_valid, dec_mre, dec_mwe;
   logic [31:0] dec_op1, dec_op2;
   logic [6:0]  aluctl, dec_rd, dec_branch;
   logic [26:0] npc;
   logic [29:0] daddr;

   decode_scoreboard #(
      .XLEN(32), .PCW(27), .REG_AW(6), .LOAD_LAT(LOAD_LAT), .FPU_LAT(FPU_LAT), .MAX_LAT(7)
   ) dut (
      .clk(clk), .rst(rst), .n_stall(n_stall), .flush(flush), .inst_valid(inst_valid),
      .inst(inst), .pc(pc), .dec_nstall(dec_nstall), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_rs1data(rf_rs1data), .rf_rs2data(rf_rs2data), .alu_fwd(alu_fwd), .wb_we(wb_we),
      .wb_rd(wb_rd), .wb_data(wb_data), .dec_valid(dec_valid), .dec_op1(dec_op1),
      .dec_op2(dec_op2), .aluctl(aluctl), .dec_rd(dec_rd), .dec_mre(dec_mre),
      .dec_mwe(dec_mwe), .dec_branch(dec_branch), .npc(npc), .daddr(daddr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: remaining cycles per register plus the expected output bundle.
   int          m_pend[64];
   logic        m_valid, m_mre, m_mwe;
   int          m_cls;
   logic [31:0] m_op1, m_op2;
   logic [6:0]  m_aluctl, m_rd, m_branch;
   logic [26:0] m_npc;
   logic [29:0] m_daddr;

   // Environment values driven with the next step.
   logic        g_we;
   logic [5:0]  g_wrd;
   logic [31:0] g_wdat, g_afwd, g_r1d, g_r2d;
   logic [26:0] g_pc;
   logic        last_nstall;

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // 0 = no destination, 1 = ALU, 2 = load, 3 = FPU
   function automatic int cls_of(input int op, input int fn);
      if (op == 2) return 3;
      if (op == 5 && fn < 2) return 2;
      if (op == 0 || op == 1 || op == 3 || op == 4 || (op == 5 && fn == 2)) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] pick(input int s, input logic [31:0] rfv);
      if (m_valid && m_cls == 1 && int'(m_rd[5:0]) == s && (s % 32) != 0) return g_afwd;
      if (g_we && int'(g_wrd) == s && (s % 32) != 0) return g_wdat;
      return rfv;
   endfunction

   function automatic logic [31:0] mk(input int op, input int fn, input int rd, input int rs1,
                                      input int rs2);
      logic [31:0] v;
      v        = 32'd0;
      v[2:0]   = op[2:0];
      v[5:3]   = fn[2:0];
      v[10:6]  = rs2[4:0];
      v[26:22] = rd[4:0];
      v[31:27] = rs1[4:0];
      return v;
   endfunction

   task automatic step(input logic ns, input logic fl, input logic iv, input logic [31:0] in);
      int          op, fn, s1, s2, d, c, lt, fb;
      logic        exp_ns, iss;
      logic [31:0] il, sb, v1, v2;
      @(negedge clk);
      n_stall = ns; flush = fl; inst_valid = iv; inst = in; pc = g_pc;
      wb_we = g_we; wb_rd = g_wrd; wb_data = g_wdat; alu_fwd = g_afwd;
      rf_rs1data = g_r1d; rf_rs2data = g_r2d;
      #1;
      op = int'(in[2:0]);
      fn = int'(in[5:3]);
      fb = (op == 2 || (op == 3 && fn < 4)) ? 32 : 0;
      s1 = fb + int'(in[31:27]);
      s2 = fb + int'(in[10:6]);
      d  = ((op == 2 || (op == 3 && fn >= 4)) ? 32 : 0) + int'(in[26:22]);
      c  = cls_of(op, fn);
      lt = (c == 2) ? LOAD_LAT : (c == 3) ? FPU_LAT : 0;
      exp_ns = !(iv && (m_pend[s1] != 0 || m_pend[s2] != 0 || (c != 0 && m_pend[d] != 0)));
      chk_val("rf_rs1", rf_rs1, s1);
      chk_val("rf_rs2", rf_rs2, s2);
      chk_val("dec_nstall", dec_nstall, exp_ns);
      last_nstall = dec_nstall;
      v1  = pick(s1, g_r1d);
      v2  = pick(s2, g_r2d);
      il  = 32'($signed(in[21:6]));
      sb  = 32'($signed(in[26:11]));
      iss = ns && iv && exp_ns && !fl;
      if (ns) begin
         for (int r = 0; r < 64; r++) if (m_pend[r] > 0) m_pend[r]--;
         if (fl && m_valid && m_cls >= 2) m_pend[int'(m_rd[5:0])] = 0;
         if (iss && lt > 0 && (d % 32) != 0) m_pend[d] = lt;
         if (fl) begin
            m_valid = 0; m_cls = 0; m_op1 = 0; m_op2 = 0; m_aluctl = 0; m_rd = 0;
            m_mre = 0; m_mwe = 0; m_branch = 0; m_npc = 0; m_daddr = 0;
         end else if (iss) begin
            m_valid  = 1;
            m_cls    = c;
            m_op1    = v1;
            m_op2    = (op == 4 || op == 5 || op == 7) ? il : v2;
            m_aluctl = 7'((in[11] ? 64 : 0) + op * 8 + fn);
            m_rd     = 7'((c != 0 ? 64 : 0) + d);
            m_mre    = (c == 2);
            m_mwe    = (op == 5 && fn >= 4);
            m_branch = (op == 6) ? 7'(64 + (fn < 6 ? (1 << fn) : 0)) : 7'd0;
            m_npc    = 27'(g_pc + (sb << 2));
            m_daddr  = 30'(v1 + ((op == 5) ? il : sb));
         end else begin
            m_valid = 0; m_cls = 0; m_aluctl = 0; m_rd = 0; m_mre = 0; m_mwe = 0; m_branch = 0;
         end
      end
      @(posedge clk);
      #1;
      chk_val("dec_valid", dec_valid, m_valid);
      chk_val("dec_op1", dec_op1, m_op1);
      chk_val("dec_op2", dec_op2, m_op2);
      chk_val("aluctl", aluctl, m_aluctl);
      chk_val("dec_rd", dec_rd, m_rd);
      chk_val("dec_mre", dec_mre, m_mre);
      chk_val("dec_mwe", dec_mwe, m_mwe);
      chk_val("dec_branch", dec_branch, m_branch);
      chk_val("npc", npc, m_npc);
      chk_val("daddr", daddr, m_daddr);
   endtask

   // Present one instruction until it issues; ns_hold selects cycles with n_stall low.
   task automatic run_until_issue(input logic [31:0] in, input int hold_from, input int hold_len,
                                  output int stalls);
      logic ns;
      stalls = 0;
      for (int k = 0; k < 12; k++) begin
         ns = !(k >= hold_from && k < hold_from + hold_len);
         step(ns, 1'b0, 1'b1, in);
         if (ns && last_nstall) break;
         if (!last_nstall) stalls++;
      end
   endtask

   int stalls;

   initial begin
      for (int r = 0; r < 64; r++) m_pend[r] = 0;
      m_valid = 0; m_cls = 0; m_op1 = 0; m_op2 = 0; m_aluctl = 0; m_rd = 0;
      m_mre = 0; m_mwe = 0; m_branch = 0; m_npc = 0; m_daddr = 0;
      g_we = 0; g_wrd = 0; g_wdat = 0; g_afwd = 0; g_r1d = 0; g_r2d = 0; g_pc = 0;
      rst = 1; n_stall = 1; flush = 0; inst_valid = 0; inst = 0; pc = 0;
      wb_we = 0; wb_rd = 0; wb_data = 0; alu_fwd = 0; rf_rs1data = 0; rf_rs2data = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_val("rst_valid", dec_valid, 0);
      chk_val("rst_op1", dec_op1, 0);
      chk_val("rst_op2", dec_op2, 0);
      chk_val("rst_aluctl", aluctl, 0);
      chk_val("rst_rd", dec_rd, 0);
      chk_val("rst_branch", dec_branch, 0);
      chk_val("rst_npc", npc, 0);
      chk_val("rst_daddr", daddr, 0);
      @(negedge clk);
      rst = 0;
      #1;
      chk_val("rst_nstall", dec_nstall, 1);

      // ALU forwarding into the next instruction
      g_r1d = 32'h1111; g_r2d = 32'h2222;
      step(1, 0, 1, mk(0, 0, 3, 0, 0));
      g_afwd = 32'h55;
      step(1, 0, 1, mk(0, 0, 4, 3, 1));
      chk_val("fwd_nstall", last_nstall, 1);
      chk_val("fwd_op1", dec_op1, 32'h55);

      // Load-use: two stall cycles, then issue with the writeback value
      step(1, 0, 1, mk(5, 0, 5, 0, 0));
      step(1, 0, 1, mk(0, 0, 6, 5, 0));
      chk_val("lu_stall1", last_nstall, 0);
      step(1, 0, 1, mk(0, 0, 6, 5, 0));
      chk_val("lu_stall2", last_nstall, 0);
      g_we = 1; g_wrd = 6'd5; g_wdat = 32'h1234;
      step(1, 0, 1, mk(0, 0, 6, 5, 0));
      chk_val("lu_issue", last_nstall, 1);
      chk_val("lu_op1", dec_op1, 32'h1234);
      g_we = 0;

      // FPU dependency on f2 stalls three cycles; integer r2 is a different register
      step(1, 0, 1, mk(2, 0, 2, 0, 0));
      run_until_issue(mk(2, 0, 4, 2, 0), 99, 0, stalls);
      chk_val("fpu_stalls", stalls, 3);
      step(1, 0, 1, mk(2, 0, 2, 0, 0));
      step(1, 0, 1, mk(0, 0, 9, 2, 0));
      chk_val("int_r2_nstall", last_nstall, 1);

      // Flushed load releases its destination immediately
      step(1, 0, 1, mk(5, 0, 7, 0, 0));
      step(1, 1, 0, 32'd0);
      chk_val("flush_valid", dec_valid, 0);
      g_r1d = 32'hABCD;
      step(1, 0, 1, mk(0, 0, 8, 7, 0));
      chk_val("flush_nstall", last_nstall, 1);
      chk_val("flush_op1", dec_op1, 32'hABCD);

      // Frozen pipeline holds the load countdown
      step(1, 0, 1, mk(5, 0, 5, 0, 0));
      run_until_issue(mk(0, 0, 6, 5, 0), 1, 3, stalls);
      chk_val("frozen_stalls", stalls, 5);
      step(1, 0, 1, mk(5, 0, 0, 0, 0));
      step(1, 0, 1, mk(0, 0, 6, 0, 0));
      chk_val("r0_nstall", last_nstall, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] in;
         in        = $urandom;
         in[2:0]   = 3'($urandom_range(0, 7));
         in[10:6]  = 5'($urandom_range(0, 3));
         in[26:22] = 5'($urandom_range(0, 3));
         in[31:27] = 5'($urandom_range(0, 3));
         g_we   = ($urandom_range(0, 1) == 1);
         g_wrd  = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
         g_wdat = $urandom; g_afwd = $urandom; g_r1d = $urandom; g_r2d = $urandom;
         g_pc   = 27'($urandom);
         step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 80, in);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
